decode_writeback: RTL

- Register-file stage directly downstream of the sequential Y86-64 fetch stage.
- Consumes fetch outputs (icode, rA, rB) and decodes source and destination register IDs.
- Drives valA/valB combinationally to the execute stage.
- Commits valE/valM to the 15-entry, 64-bit register file on the rising clk edge, in the writeback phase of the same instruction.

---
 rtl/decode_writeback.sv | 104 ++++++++++
 1 files changed

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register-ID decode, 15x64 register file.
// Optional DECODE_BYPASS_EN forwards in-flight valM/valE onto valA/valB.
module decode_writeback #(
  parameter logic [63:0] RSP_RESET = 64'h0,
  parameter logic [3:0]  RNONE     = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB
);

  localparam logic [3:0] RSP = 4'h4;

  logic [63:0] regs [0:14];
  logic [63:0] rd_a;
  logic [63:0] rd_b;

  always_comb begin
    srcA = RNONE;
    unique case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: srcA = rA;
      4'h9, 4'hB:             srcA = RSP;
      default:                srcA = RNONE;
    endcase
  end

  always_comb begin
    srcB = RNONE;
    unique case (icode)
      4'h4, 4'h5, 4'h6:       srcB = rB;
      4'h8, 4'h9, 4'hA, 4'hB: srcB = RSP;
      default:                srcB = RNONE;
    endcase
  end

  always_comb begin
    dstE = RNONE;
    unique case (icode)
      4'h2:                   dstE = cnd ? rB : RNONE;
      4'h3, 4'h6:             dstE = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
      default:                dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    unique case (icode)
      4'h5, 4'hB: dstM = rA;
      default:    dstM = RNONE;
    endcase
  end

  assign rd_a = (srcA == RNONE) ? 64'h0 : regs[srcA];
  assign rd_b = (srcB == RNONE) ? 64'h0 : regs[srcB];

`ifdef DECODE_BYPASS_EN
  // dstM is checked first so a popq-style collision forwards valM.
  always_comb begin
    valA = rd_a;
    if (wb_en && srcA != RNONE && srcA == dstM)
      valA = valM;
    else if (wb_en && srcA != RNONE && srcA == dstE)
      valA = valE;
  end

  always_comb begin
    valB = rd_b;
    if (wb_en && srcB != RNONE && srcB == dstM)
      valB = valM;
    else if (wb_en && srcB != RNONE && srcB == dstE)
      valB = valE;
  end
`else
  assign valA = rd_a;
  assign valB = rd_b;
`endif

  // The M write is issued last so it wins when dstE == dstM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++)
        regs[i] <= (i == 4) ? RSP_RESET : 64'h0;
    end else if (wb_en) begin
      if (dstE != RNONE)
        regs[dstE] <= valE;
      if (dstM != RNONE)
        regs[dstM] <= valM;
    end
  end

endmodule
